// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and constants for the LED bank arbiter and its round-robin picker.
package led_arb_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_HOLD = 2'd1,
        OWN_OPEN = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Index width for n requesters; never zero so a single-bit index still exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Requester-side bundle of the LED bank arbiter: requests, packed data, grant and LED drive.
interface led_bank_arbiter_if
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = LED_W
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         led;
    logic                     busy;

    modport master (output req, data, input gnt, led, busy);
    modport slave  (input req, data, output gnt, led, busy);
endinterface

// File: rtl/led_bank_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1 with wrap.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any
);
    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        // k runs 1..N so the previous winner is examined last.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED bank with a minimum hold time and a blank gap between owners.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int               NUM_REQ      = 3,
    parameter int               WIDTH        = LED_W,
    parameter int               MIN_HOLD     = 1024,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic               clk,
    input  logic               rst,
    led_bank_arbiter_if.slave  bus
);
    localparam int                 IW  = idx_w(NUM_REQ);
    localparam int                 CW  = $clog2(MIN_HOLD + 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0]   led_q, led_d;

    logic [IW-1:0]      win;
    logic               any_req;
    logic               owner_req;
    logic               other_req;
    logic [WIDTH-1:0]   owner_data;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (win),
        .any    (any_req)
    );

    // last_q doubles as the owner index: it is loaded with the winner on every grant.
    assign owner_req  = bus.req[last_q];
    assign other_req  = |(bus.req & ~(ONE << last_q));
    assign owner_data = bus.data[last_q*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        led_d   = led_q;
        case (state_q)
            IDLE, GAP: begin
                led_d = IDLE_PATTERN;
                gnt_d = '0;
                if (any_req) begin
                    state_d = OWN_HOLD;
                    last_d  = win;
                    cnt_d   = CW'(MIN_HOLD - 1);
                    gnt_d   = ONE << win;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_HOLD: begin
                led_d = owner_data;
                if (!owner_req) begin
                    state_d = GAP;
                    gnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = OWN_OPEN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            OWN_OPEN: begin
                led_d = owner_data;
                if (!owner_req || other_req) begin
                    state_d = GAP;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                led_d   = IDLE_PATTERN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            led_q   <= IDLE_PATTERN;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            led_q   <= led_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.led  = led_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed scoreboard bench for led_bank_arbiter with NUM_REQ=3, MIN_HOLD=4.
module tb_led_bank_arbiter;
    import led_arb_pkg::*;

    localparam int NR = 3;
    localparam int W  = 8;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_bank_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    led_bank_arbiter #(
        .NUM_REQ(NR), .WIDTH(W), .MIN_HOLD(MH), .IDLE_PATTERN(8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic [2:0] g;
        logic [7:0] l;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [7:0] D0 = 8'h3C;
    localparam logic [7:0] D1 = 8'hA5;
    localparam logic [7:0] D2 = 8'h5A;

    task automatic push_exp(input string tag, input logic [2:0] g, input logic [7:0] l, input logic b);
        exp_t e;
        e.tag = tag; e.g = g; e.l = l; e.b = b;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_chk++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            assert (bus.gnt === e.g) else begin
                n_fail++;
                $error("FAIL %s gnt: observed %b expected %b", e.tag, bus.gnt, e.g);
            end
            n_chk++;
            assert (bus.led === e.l) else begin
                n_fail++;
                $error("FAIL %s led: observed %h expected %h", e.tag, bus.led, e.l);
            end
            n_chk++;
            assert (bus.busy === e.b) else begin
                n_fail++;
                $error("FAIL %s busy: observed %b expected %b", e.tag, bus.busy, e.b);
            end
        end
    endtask

    // Drive req, record what the outputs must be after the next edge, then compare.
    task automatic step(input logic [2:0] r, input logic [2:0] g, input logic [7:0] l,
                        input logic b, input string tag);
        bus.req = r;
        push_exp(tag, g, l, b);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [2:0] oh;
        logic [7:0] dv;
        rst      = 1'b1;
        bus.req  = '0;
        bus.data = {D2, D1, D0};
        #2;
        push_exp("reset_state", 3'b000, 8'h00, 1'b0);
        check_out();
        #10;
        rst = 1'b0;

        // single requester: grant, data one edge later, one blank cycle, then idle
        step(3'b001, 3'b001, 8'h00, 1'b1, "single_grant");
        step(3'b001, 3'b001, D0,    1'b1, "single_led");
        step(3'b000, 3'b000, D0,    1'b1, "single_gap");
        step(3'b000, 3'b000, 8'h00, 1'b0, "single_idle");

        // minimum hold: req[1] joins after the grant but cannot preempt
        step(3'b001, 3'b001, 8'h00, 1'b1, "hold_grant");
        for (int i = 0; i < 3; i++) step(3'b011, 3'b001, D0, 1'b1, "hold_cnt");
        step(3'b011, 3'b001, D0,    1'b1, "hold_expire");
        step(3'b011, 3'b000, D0,    1'b1, "hold_gap");
        step(3'b011, 3'b010, 8'h00, 1'b1, "hold_next_grant");
        step(3'b011, 3'b010, D1,    1'b1, "hold_next_led");

        // reset mid-grant takes effect before the next edge
        #2;
        rst = 1'b1;
        #1;
        push_exp("reset_mid_grant", 3'b000, 8'h00, 1'b0);
        check_out();
        bus.req = 3'b000;
        #1;
        rst = 1'b0;
        step(3'b000, 3'b000, 8'h00, 1'b0, "post_reset_idle");

        // round robin with all three requesting; requester 0 first after reset
        for (int k = 0; k < 4; k++) begin
            oh = 3'b001 << (k % 3);
            dv = (k % 3 == 0) ? D0 : (k % 3 == 1) ? D1 : D2;
            step(3'b111, oh, 8'h00, 1'b1, "rr_grant");
            if (k < 3) begin
                for (int i = 0; i < 4; i++) step(3'b111, oh, dv, 1'b1, "rr_own");
                step(3'b111, 3'b000, dv, 1'b1, "rr_gap");
            end
        end
        step(3'b000, 3'b000, D0,    1'b1, "rr_release");
        step(3'b000, 3'b000, 8'h00, 1'b0, "rr_idle");

        // early release by requester 2 while requester 0 waits
        step(3'b100, 3'b100, 8'h00, 1'b1, "early_grant");
        step(3'b101, 3'b100, D2,    1'b1, "early_own");
        step(3'b001, 3'b000, D2,    1'b1, "early_gap");
        step(3'b001, 3'b001, 8'h00, 1'b1, "early_next_grant");
        step(3'b001, 3'b001, D0,    1'b1, "early_next_led");
        step(3'b000, 3'b000, D0,    1'b1, "early_next_gap");
        step(3'b000, 3'b000, 8'h00, 1'b0, "early_idle");

        // release on the hold-expiry edge; owner data tracked, non-owner data ignored
        step(3'b010, 3'b010, 8'h00, 1'b1, "coll_grant");
        step(3'b010, 3'b010, D1,    1'b1, "coll_own1");
        bus.data = {D2, 8'h77, 8'hEE};
        step(3'b010, 3'b010, 8'h77, 1'b1, "coll_data_follow");
        step(3'b010, 3'b010, 8'h77, 1'b1, "coll_own3");
        step(3'b000, 3'b000, 8'h77, 1'b1, "coll_gap");
        step(3'b000, 3'b000, 8'h00, 1'b0, "coll_idle");

        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
